// File: rtl/seg_scan_controller_if.sv
// Display-side bundle of the scan controller: control/data in, decoder nibble, anodes and status pulses out.
interface seg_scan_controller_if #(
  parameter int DIGITS = 4
);
  logic                  enable;
  logic                  load;
  logic [4*DIGITS-1:0]   bcd_in;
  logic [3:0]            bcd_out;
  logic [DIGITS-1:0]     an;
  logic                  frame_start;
  logic                  load_done;

  modport master (
    output enable, load, bcd_in,
    input  bcd_out, an, frame_start, load_done
  );

  modport slave (
    input  enable, load, bcd_in,
    output bcd_out, an, frame_start, load_done
  );
endinterface

// File: rtl/seg_scan_controller.sv
// Multiplexes one BCD-to-7-segment decoder across DIGITS common-anode digits, with blanking and frame-aligned double buffering.
// Optional macro LEADING_ZERO_BLANK_EN darkens leading zero digits (digit 0 always lights).
module seg_scan_controller #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  seg_scan_controller_if.slave bus
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam state_t SLOT_FIRST = (BLANK_CYCLES > 0) ? BLANK : SHOW;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [4*DIGITS-1:0] staged_q, staged_d;
  logic                pending_q, pending_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [3:0]          bcd_q, bcd_d;
  logic                fs_q, fs_d;
  logic                ld_q, ld_d;
  logic                wrap;
  logic                boundary;
  logic [DIGITS-1:0]   dark;
`ifdef LEADING_ZERO_BLANK_EN
  logic                upper_zero;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      shadow_q  <= '0;
      staged_q  <= '0;
      pending_q <= 1'b0;
      an_q      <= '1;
      bcd_q     <= '0;
      fs_q      <= 1'b0;
      ld_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      staged_q  <= staged_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      bcd_q     <= bcd_d;
      fs_q      <= fs_d;
      ld_q      <= ld_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q + CW'(1);
    shadow_d  = shadow_q;
    staged_d  = staged_q;
    pending_d = pending_q;
    fs_d      = 1'b0;
    ld_d      = 1'b0;
    wrap      = 1'b0;

    case (state_q)
      IDLE: begin
        idx_d = '0;
        cnt_d = '0;
        if (bus.enable) begin
          state_d = SLOT_FIRST;
          fs_d    = 1'b1;
        end
      end
      BLANK: begin
        if (!bus.enable) begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == BLANK_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
        end
      end
      SHOW: begin
        if (!bus.enable) begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == SHOW_LAST) begin
          state_d = SLOT_FIRST;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            wrap  = 1'b1;
            fs_d  = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase

    // Older staged value is committed before a same-cycle load re-arms pending.
    boundary = wrap || (state_q == IDLE);
    if (boundary && pending_q) begin
      shadow_d  = staged_q;
      pending_d = 1'b0;
      ld_d      = 1'b1;
    end
    if (bus.load) begin
      staged_d  = bus.bcd_in;
      pending_d = 1'b1;
    end
  end

  always_comb begin
    dark = '0;
`ifdef LEADING_ZERO_BLANK_EN
    upper_zero = 1'b1;
`endif
    for (int i = DIGITS - 1; i >= 0; i--) begin
      dark[i] = (shadow_d[4*i +: 4] > 4'd9);
`ifdef LEADING_ZERO_BLANK_EN
      upper_zero = upper_zero && (shadow_d[4*i +: 4] == 4'd0);
      if ((i > 0) && upper_zero) dark[i] = 1'b1;
`endif
    end
  end

  // Outputs are computed from next-state values so they register in step with the FSM.
  always_comb begin
    an_d  = '1;
    bcd_d = '0;
    if (state_d != IDLE) bcd_d = shadow_d[4*idx_d +: 4];
    if ((state_d == SHOW) && !dark[idx_d]) an_d[idx_d] = 1'b0;
  end

  assign bus.an          = an_q;
  assign bus.bcd_out     = bcd_q;
  assign bus.frame_start = fs_q;
  assign bus.load_done   = ld_q;

endmodule
